// File: rtl/game_flow_ctrl.sv
// Pac-Man game-flow controller: start/ready/play/death/win/game-over sequencing,
// lives, saturating score and power-pellet frightened mode with chained ghost bonuses.
module game_flow_ctrl #(
   parameter int NUM_GHOSTS    = 2,
   parameter int START_LIVES   = 3,
   parameter int READY_FRAMES  = 120,
   parameter int DEATH_FRAMES  = 90,
   parameter int FRIGHT_FRAMES = 360,
   parameter int WARN_FRAMES   = 120
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  frame_enable,
   input  logic                  start_key,
   input  logic [NUM_GHOSTS-1:0] ghost_collision,
   input  logic                  pellet_collected,
   input  logic                  power_collected,
   input  logic                  all_pellets_cleared,
   output logic [2:0]            state,
   output logic                  move_en,
   output logic                  positions_reset,
   output logic                  board_reset,
   output logic                  frightened,
   output logic                  fright_warn,
   output logic [NUM_GHOSTS-1:0] ghost_eaten,
   output logic [3:0]            lives,
   output logic [15:0]           score,
   output logic                  game_over,
   output logic                  win
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_READY     = 3'd1;
   localparam logic [2:0] S_PLAY      = 3'd2;
   localparam logic [2:0] S_DYING     = 3'd3;
   localparam logic [2:0] S_GAME_OVER = 3'd4;
   localparam logic [2:0] S_WIN       = 3'd5;

   localparam logic [15:0] READY_LD  = 16'(READY_FRAMES);
   localparam logic [15:0] DEATH_LD  = 16'(DEATH_FRAMES);
   localparam logic [15:0] FRIGHT_LD = 16'(FRIGHT_FRAMES);
   localparam logic [15:0] WARN_LD   = 16'(WARN_FRAMES);
   localparam logic [3:0]  START_LD  = 4'(START_LIVES);

   logic [2:0]            state_nx;
   logic [15:0]           frame_cnt, frame_cnt_nx;
   logic [15:0]           fright_cnt, fright_cnt_nx;
   logic                  frightened_nx;
   logic [NUM_GHOSTS-1:0] mask, mask_nx, hit, eat_sel, eaten_nx;
   logic [1:0]            eat_k, eat_k_nx;
   logic [3:0]            lives_nx;
   logic [15:0]           score_nx;
   logic [16:0]           add_sum, score_sum;
   logic                  pos_rst_nx, brd_rst_nx;

   always_comb begin
      state_nx      = state;
      frame_cnt_nx  = frame_cnt;
      fright_cnt_nx = fright_cnt;
      frightened_nx = frightened;
      mask_nx       = mask;
      eat_k_nx      = eat_k;
      lives_nx      = lives;
      score_nx      = score;
      pos_rst_nx    = 1'b0;
      brd_rst_nx    = 1'b0;
      eaten_nx      = '0;
      add_sum       = '0;
      score_sum     = '0;
      hit           = ghost_collision & ~mask;
      // isolate the lowest-index unmasked collider
      eat_sel       = hit & (-hit);

      case (state)
         S_IDLE, S_GAME_OVER, S_WIN: begin
            if (start_key) begin
               state_nx     = S_READY;
               frame_cnt_nx = READY_LD;
               pos_rst_nx   = 1'b1;
               brd_rst_nx   = 1'b1;
               lives_nx     = START_LD;
               score_nx     = '0;
            end
         end
         S_READY: begin
            if (frame_enable) begin
               if (frame_cnt <= 16'd1) begin
                  state_nx     = S_PLAY;
                  frame_cnt_nx = '0;
               end else begin
                  frame_cnt_nx = frame_cnt - 16'd1;
               end
            end
         end
         S_PLAY: begin
            if (pellet_collected) add_sum = add_sum + 17'd10;
            if (power_collected)  add_sum = add_sum + 17'd50;

            if (all_pellets_cleared) begin
               state_nx = S_WIN;
            end else if (frightened && (|hit)) begin
               eaten_nx = eat_sel;
               mask_nx  = mask | eat_sel;
               add_sum  = add_sum + (17'd200 << eat_k);
               if (eat_k != 2'd3) eat_k_nx = eat_k + 2'd1;
            end else if (!frightened && (|ghost_collision)) begin
               state_nx     = S_DYING;
               frame_cnt_nx = DEATH_LD;
               if (lives != 4'd0) lives_nx = lives - 4'd1;
            end

            // expiry is applied after an eat in the same cycle so the period ends clean
            if (frightened && frame_enable) begin
               if (fright_cnt <= 16'd1) begin
                  frightened_nx = 1'b0;
                  fright_cnt_nx = '0;
                  mask_nx       = '0;
                  eat_k_nx      = '0;
               end else begin
                  fright_cnt_nx = fright_cnt - 16'd1;
               end
            end

            if (power_collected) begin
               frightened_nx = 1'b1;
               fright_cnt_nx = FRIGHT_LD;
               mask_nx       = '0;
               eat_k_nx      = '0;
            end

            if (state_nx != S_PLAY) begin
               frightened_nx = 1'b0;
               fright_cnt_nx = '0;
               mask_nx       = '0;
               eat_k_nx      = '0;
            end

            score_sum = {1'b0, score} + add_sum;
            score_nx  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
         end
         S_DYING: begin
            if (frame_enable) begin
               if (frame_cnt <= 16'd1) begin
                  if (lives == 4'd0) begin
                     state_nx     = S_GAME_OVER;
                     frame_cnt_nx = '0;
                  end else begin
                     state_nx     = S_READY;
                     frame_cnt_nx = READY_LD;
                     pos_rst_nx   = 1'b1;
                  end
               end else begin
                  frame_cnt_nx = frame_cnt - 16'd1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         frame_cnt       <= '0;
         fright_cnt      <= '0;
         frightened      <= 1'b0;
         fright_warn     <= 1'b0;
         mask            <= '0;
         eat_k           <= '0;
         lives           <= START_LD;
         score           <= '0;
         ghost_eaten     <= '0;
         positions_reset <= 1'b0;
         board_reset     <= 1'b0;
         move_en         <= 1'b0;
         game_over       <= 1'b0;
         win             <= 1'b0;
      end else begin
         state           <= state_nx;
         frame_cnt       <= frame_cnt_nx;
         fright_cnt      <= fright_cnt_nx;
         frightened      <= frightened_nx;
         fright_warn     <= frightened_nx && (fright_cnt_nx <= WARN_LD);
         mask            <= mask_nx;
         eat_k           <= eat_k_nx;
         lives           <= lives_nx;
         score           <= score_nx;
         ghost_eaten     <= eaten_nx;
         positions_reset <= pos_rst_nx;
         board_reset     <= brd_rst_nx;
         move_en         <= (state_nx == S_PLAY);
         game_over       <= (state_nx == S_GAME_OVER);
         win             <= (state_nx == S_WIN);
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus queues expected snapshots,
// a monitor compares them whenever the DUT shows a pulse, a state change or a reset.
module tb_game_flow_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       frame_enable, start_key, pellet_collected, power_collected, all_pellets_cleared;
   logic [1:0] ghost_collision;
   logic [2:0] state;
   logic       move_en, positions_reset, board_reset, frightened, fright_warn, game_over, win;
   logic [1:0] ghost_eaten;
   logic [3:0] lives;
   logic [15:0] score;

   game_flow_ctrl #(
      .NUM_GHOSTS(2), .START_LIVES(3), .READY_FRAMES(120),
      .DEATH_FRAMES(90), .FRIGHT_FRAMES(360), .WARN_FRAMES(120)
   ) dut (
      .clk(clk), .reset_n(reset_n), .frame_enable(frame_enable), .start_key(start_key),
      .ghost_collision(ghost_collision), .pellet_collected(pellet_collected),
      .power_collected(power_collected), .all_pellets_cleared(all_pellets_cleared),
      .state(state), .move_en(move_en), .positions_reset(positions_reset),
      .board_reset(board_reset), .frightened(frightened), .fright_warn(fright_warn),
      .ghost_eaten(ghost_eaten), .lives(lives), .score(score),
      .game_over(game_over), .win(win)
   );

   always #20 clk = ~clk;

   typedef struct {
      string       nm;
      logic [2:0]  st;
      logic        mv;
      logic [3:0]  lv;
      logic [15:0] sc;
      logic        fr, fw;
      logic [1:0]  ge;
      logic        pr, br, go, wn;
      int          fno;
   } snap_t;

   snap_t exp_q[$];
   int    n_tests = 0, n_fail = 0;
   int    nf = 0, frames_seen = 0;

   logic [2:0]  e_st;
   logic [3:0]  e_lv;
   logic [15:0] e_sc;
   logic        e_fr, e_fw;

   function automatic string fmt(input snap_t s);
      return $sformatf("st=%0d mv=%0d lv=%0d sc=%h fr=%0d fw=%0d ge=%b pr=%0d br=%0d go=%0d wn=%0d frame=%0d",
                       s.st, s.mv, s.lv, s.sc, s.fr, s.fw, s.ge, s.pr, s.br, s.go, s.wn, s.fno);
   endfunction

   function automatic bit same(input snap_t a, input snap_t b);
      return (a.st === b.st) && (a.mv === b.mv) && (a.lv === b.lv) && (a.sc === b.sc) &&
             (a.fr === b.fr) && (a.fw === b.fw) && (a.ge === b.ge) && (a.pr === b.pr) &&
             (a.br === b.br) && (a.go === b.go) && (a.wn === b.wn) && (a.fno == b.fno);
   endfunction

   function automatic bit core_diff(input snap_t a, input snap_t b);
      return (a.st !== b.st) || (a.mv !== b.mv) || (a.lv !== b.lv) || (a.sc !== b.sc) ||
             (a.fr !== b.fr) || (a.fw !== b.fw) || (a.go !== b.go) || (a.wn !== b.wn);
   endfunction

   task automatic push(input string nm, input logic [1:0] ge, input logic pr, input logic br);
      snap_t s;
      s.nm = nm; s.st = e_st; s.mv = (e_st == 3'd2); s.lv = e_lv; s.sc = e_sc;
      s.fr = e_fr; s.fw = e_fw; s.ge = ge; s.pr = pr; s.br = br;
      s.go = (e_st == 3'd4); s.wn = (e_st == 3'd5); s.fno = nf;
      exp_q.push_back(s);
   endtask

   // one clock of stimulus, entered and left at posedge+1
   task automatic drive(input logic fe, input logic pel, input logic pow);
      frame_enable = fe; pellet_collected = pel; power_collected = pow;
      @(posedge clk);
      #1;
      frame_enable = 1'b0; pellet_collected = 1'b0; power_collected = 1'b0;
      if (fe) nf++;
   endtask

   task automatic ready_run();
      for (int i = 1; i <= 120; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         if (i == 120) begin e_st = 3'd2; push("ready_to_play", 2'b00, 1'b0, 1'b0); end
      end
   endtask

   task automatic fright_run(input int from);
      for (int j = from + 1; j <= 360; j++) begin
         drive(1'b1, 1'b0, 1'b0);
         if (j == 240) begin e_fw = 1'b1; push("fright_warn", 2'b00, 1'b0, 1'b0); end
         if (j == 360) begin e_fr = 1'b0; e_fw = 1'b0; push("fright_end", 2'b00, 1'b0, 1'b0); end
      end
   endtask

   task automatic death_run(input bit to_go);
      for (int i = 1; i <= 90; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         if (i == 90) begin
            if (to_go) begin e_st = 3'd4; push("game_over", 2'b00, 1'b0, 1'b0); end
            else begin e_st = 3'd1; push("respawn", 2'b00, 1'b1, 1'b0); end
         end
      end
   endtask

   task automatic die(input string nm, input logic [3:0] lv_after);
      ghost_collision = 2'b01;
      drive(1'b0, 1'b0, 1'b0);
      ghost_collision = 2'b00;
      e_st = 3'd3; e_lv = lv_after;
      push(nm, 2'b00, 1'b0, 1'b0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (frame_enable) frames_seen++;
      end
   end

   initial begin
      snap_t cur, prev, ex;
      logic  prev_rst;
      bit    trig;
      prev_rst = 1'b1;
      forever begin
         @(negedge clk);
         cur.nm = ""; cur.st = state; cur.mv = move_en; cur.lv = lives; cur.sc = score;
         cur.fr = frightened; cur.fw = fright_warn; cur.ge = ghost_eaten;
         cur.pr = positions_reset; cur.br = board_reset; cur.go = game_over; cur.wn = win;
         cur.fno = frames_seen;
         trig = (!reset_n && prev_rst) ||
                (reset_n && ((cur.ge != 2'b00) || cur.pr || cur.br || core_diff(cur, prev)));
         if (trig) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: got {%s} required {no event}", fmt(cur));
            end else begin
               ex = exp_q.pop_front();
               if (!same(cur, ex)) begin
                  n_fail++;
                  $display("FAIL %s: got {%s} required {%s}", ex.nm, fmt(cur), fmt(ex));
               end
            end
         end
         prev = cur;
         prev_rst = reset_n;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      frame_enable = 1'b0; start_key = 1'b0; ghost_collision = 2'b00;
      pellet_collected = 1'b0; power_collected = 1'b0; all_pellets_cleared = 1'b0;
      e_st = 3'd0; e_lv = 4'd3; e_sc = 16'd0; e_fr = 1'b0; e_fw = 1'b0;
      push("reset", 2'b00, 1'b0, 1'b0);
      #5 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0);

      // new game: both reset pulses, then exactly 120 frames of READY
      start_key = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      start_key = 1'b0;
      e_st = 3'd1;
      push("start", 2'b00, 1'b1, 1'b1);
      ready_run();

      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'b0);
         e_sc = e_sc + 16'd10;
         push("pellet", 2'b00, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b0, 1'b1);
      e_sc = 16'd80; e_fr = 1'b1;
      push("power", 2'b00, 1'b0, 1'b0);
      repeat (100) drive(1'b1, 1'b0, 1'b0);

      // two ghosts overlapping at once are eaten on consecutive cycles; holding them is harmless
      ghost_collision = 2'b11;
      drive(1'b0, 1'b0, 1'b0);
      e_sc = 16'd280;
      push("eat_g0", 2'b01, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      e_sc = 16'd680;
      push("eat_g1", 2'b10, 1'b0, 1'b0);
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      ghost_collision = 2'b00;
      fright_run(100);

      // fill score to 0xFFBE, then pellet+power together, then a ghost past the top
      for (int i = 0; i < 6479; i++) begin
         drive(1'b0, 1'b1, 1'b0);
         e_sc = e_sc + 16'd10;
         push("pellet_fill", 2'b00, 1'b0, 1'b0);
      end
      drive(1'b0, 1'b1, 1'b1);
      e_sc = 16'hFFFA; e_fr = 1'b1;
      push("pellet_power_sum", 2'b00, 1'b0, 1'b0);
      ghost_collision = 2'b01;
      drive(1'b0, 1'b0, 1'b0);
      ghost_collision = 2'b00;
      e_sc = 16'hFFFF;
      push("eat_saturate", 2'b01, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      fright_run(0);

      die("death_lv2", 4'd2);
      death_run(1'b0);
      ready_run();
      die("death_lv1", 4'd1);
      death_run(1'b0);
      ready_run();
      die("death_lv0", 4'd0);
      death_run(1'b1);

      // start held from GAME_OVER restarts once and is not resampled in READY/PLAY
      start_key = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      e_st = 3'd1; e_lv = 4'd3; e_sc = 16'd0;
      push("restart_from_go", 2'b00, 1'b1, 1'b1);
      ready_run();
      start_key = 1'b0;

      all_pellets_cleared = 1'b1;
      ghost_collision = 2'b01;
      drive(1'b0, 1'b1, 1'b0);
      all_pellets_cleared = 1'b0;
      ghost_collision = 2'b00;
      e_st = 3'd5; e_sc = 16'd10;
      push("win_over_death", 2'b00, 1'b0, 1'b0);

      start_key = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      start_key = 1'b0;
      e_st = 3'd1; e_sc = 16'd0;
      push("restart_from_win", 2'b00, 1'b1, 1'b1);
      repeat (50) drive(1'b1, 1'b0, 1'b0);

      e_st = 3'd0; e_lv = 4'd3; e_sc = 16'd0; e_fr = 1'b0; e_fw = 1'b0;
      push("async_reset", 2'b00, 1'b0, 1'b0);
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (4) drive(1'b0, 1'b0, 1'b0);

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_events: got %0d unseen required 0 (next %s)", exp_q.size(), exp_q[0].nm);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
